fp_mul_pipe: RTL and testbench
==============================

# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier for the IIR datapath. Accepts one operand pair per cycle under a valid/ready handshake and returns the product three cycles later with correct special-value handling (zero, infinity, NaN), overflow to infinity, flush-to-zero underflow and status flags. Sits between the coefficient/sample fetch and the floating-point adder tree of each filter section. It is the sequential, format-generic successor to the combinational 32-bit multiplier.

## Interface
- EXP_W, 8: exponent field width (≥4)
- MAN_W, 23: stored fraction width (≥4); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept this cycle
- a, b  in  W each  operands {sign, exp, frac}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  W  product
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

## Operation
- Bias = 2^(EXP_W-1)-1. Exponent arithmetic carried in EXP_W+2 bits, signed.
- Sign = sign_a ^ sign_b, for every non-NaN result.
- Subnormal inputs (exp==0) are treated as signed zero (DAZ).
- Special-case priority: NaN input or inf×0 → canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0); invalid=1 for inf×0 only. Else inf input → ±inf. Else zero input → ±0. No flags for these.
- Normal path: significands {1,frac} multiplied to 2·(MAN_W+1) bits. If product MSB set, shift right 1, exponent+1. Exponent = ea+eb−bias(+1).
- Rounding per Configuration. Rounding carry-out (significand 10.0…) renormalises, exponent+1.
- Final exponent ≥ 2^EXP_W−1 → ±inf, overflow=1, inexact=1.
- Final exponent ≤ 0 → ±0 (FTZ), underflow=1, inexact=1.
- inexact=1 whenever discarded bits are non-zero.

## Timing
- 3-stage pipeline, latency 3 cycles from accepted input to out_valid, throughput 1/cycle.
  - S1: unpack, classify, exponent sum.
  - S2: significand product.
  - S3: normalise, round, pack, flags.
- Transfer on in_valid&&in_ready; output consumed on out_valid&&out_ready.
- Stall: in_ready = !(out_valid && !out_ready). When low, all stages hold; result/flags stable until consumed.
- Bubbles propagate as valid=0; stage registers may be clock-gated by stage valid.
- Reset: in_ready=1 after reset, out_valid=0, result=0, flags=0, all stage valids 0. Reset mid-operation discards all in-flight items; nothing is emitted.
- Simultaneous consume at output and accept at input in the same cycle is legal, with no bubble.

## Configuration
- FPMUL_RNE_EN defined: round-to-nearest, ties-to-even, using guard and sticky bits.
- Undefined: truncation (round toward zero). Overflow saturates to ±inf in both modes. Flags are identical apart from rounding effects.

## Structure
- Shared package fp_pkg: bias computation, canonical qNaN constant, class encoding (ZERO, NORM, INF, NAN), flag bit indices. The IIR adder reuses these.
- One sub-module, fp_mant_mult: registered (MAN_W+1)×(MAN_W+1) unsigned multiplier with enable, forming stage S2, so it can be replaced by a DSP-mapped version.

## Test plan
(binary32 defaults)
- 0x40400000 × 0x40000000 → 0x40C00000 after exactly 3 cycles, flags 0. 0x3FC00000 × 0x3FC00000 → 0x40100000.
- 0x3F800001 × 0x3FC00000 → 0x3FC00002 with FPMUL_RNE_EN, 0x3FC00001 without it; inexact=1 in both.
- 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1. 0x00800000 × 0x3F000000 → 0x00000000, underflow=1.
- 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1. 0xFFC00000 × 0x3F800000 → 0x7FC00000, invalid=0. 0x80000000 × 0x40000000 → 0x80000000.
- Back-to-back stream of 8 pairs with out_ready low for cycles 4–7: in_ready low while stalled, result held stable, all 8 results in order with none lost or duplicated.
- rst asserted with 2 items in flight → out_valid stays 0; next accepted pair's result appears 3 cycles after acceptance.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions,
// bias and canonical quiet-NaN helpers. Also used by the IIR adder.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  localparam int unsigned FLAG_W         = 4;
  localparam int unsigned FLAG_INEXACT   = 0;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_INVALID   = 3;

  // Widest word the qNaN helper can build; callers truncate to their width.
  localparam int unsigned FP_MAX_W = 64;

  function automatic int fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
    logic [FP_MAX_W-1:0] q;
    q = '0;
    for (int unsigned i = 0; i < exp_w; i++) q[man_w + i] = 1'b1;
    q[man_w - 1] = 1'b1;
    return q;
  endfunction

  // Subnormals (exp==0) classify as zero.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero)       return FP_ZERO;
    else if (!exp_ones) return FP_NORM;
    else if (frac_zero) return FP_INF;
    else                return FP_NAN;
  endfunction

endpackage

// File: rtl/fp_mant_mult.sv
// Registered unsigned significand multiplier (pipeline stage S2) with enable;
// kept separate so a DSP-mapped implementation can be dropped in.
module fp_mant_mult #(
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [MAN_W:0]       a_i,
  input  logic [MAN_W:0]       b_i,
  output logic [2*MAN_W+1:0]   p_o
);

  logic [2*MAN_W+1:0] p_q;

  always_ff @(posedge clk) begin
    if (rst)       p_q <= '0;
    else if (en_i) p_q <= {{(MAN_W+1){1'b0}}, a_i} * {{(MAN_W+1){1'b0}}, b_i};
  end

  assign p_o = p_q;

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic [FLAG_W-1:0]          flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;

  localparam logic signed [EW-1:0] BIAS     = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, MAN_W));

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // S1: unpack, classify, exponent sum
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  fp_class_e            cls_a, cls_b, cls1_d;
  logic                 inv1_d;
  logic signed [EW-1:0] exp1_d;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign cls_a  = fp_classify(ea == '0, ea == '1, fa == '0);
  assign cls_b  = fp_classify(eb == '0, eb == '1, fb == '0);
  assign exp1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  always_comb begin
    cls1_d = FP_NORM;
    inv1_d = 1'b0;
    if (cls_a == FP_NAN || cls_b == FP_NAN) begin
      cls1_d = FP_NAN;
    end else if ((cls_a == FP_INF && cls_b == FP_ZERO) ||
                 (cls_a == FP_ZERO && cls_b == FP_INF)) begin
      cls1_d = FP_NAN;
      inv1_d = 1'b1;
    end else if (cls_a == FP_INF || cls_b == FP_INF) begin
      cls1_d = FP_INF;
    end else if (cls_a == FP_ZERO || cls_b == FP_ZERO) begin
      cls1_d = FP_ZERO;
    end
  end

  logic                 v1_q, sign1_q, inv1_q;
  fp_class_e            cls1_q;
  logic signed [EW-1:0] exp1_q;
  logic [SW-1:0]        mana1_q, manb1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      inv1_q  <= 1'b0;
      cls1_q  <= FP_ZERO;
      exp1_q  <= '0;
      mana1_q <= '0;
      manb1_q <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      sign1_q <= sa ^ sb;
      inv1_q  <= inv1_d;
      cls1_q  <= cls1_d;
      exp1_q  <= exp1_d;
      mana1_q <= {1'b1, fa};
      manb1_q <= {1'b1, fb};
    end
  end

  // S2: significand product, side-band carried alongside
  logic [PW-1:0]        prod2;
  logic                 v2_q, sign2_q, inv2_q;
  fp_class_e            cls2_q;
  logic signed [EW-1:0] exp2_q;

  fp_mant_mult #(.MAN_W(MAN_W)) u_mant_mult (
    .clk  (clk),
    .rst  (rst),
    .en_i (adv),
    .a_i  (mana1_q),
    .b_i  (manb1_q),
    .p_o  (prod2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      inv2_q  <= 1'b0;
      cls2_q  <= FP_ZERO;
      exp2_q  <= '0;
    end else if (adv) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      inv2_q  <= inv1_q;
      cls2_q  <= cls1_q;
      exp2_q  <= exp1_q;
    end
  end

  // S3: normalise, round, pack. The hidden bit is implicit in norm_lo.
  logic                 msb, guard, sticky, round_up, rnd_carry;
  logic [PW-2:0]        norm_lo;
  logic [MAN_W:0]       frac_sum;
  logic signed [EW-1:0] exp3;
  logic [W-1:0]         res_d;
  logic [FLAG_W-1:0]    flg_d;

  assign msb     = prod2[PW-1];
  assign norm_lo = msb ? prod2[PW-2:0] : {prod2[PW-3:0], 1'b0};
  assign guard   = norm_lo[MAN_W];
  assign sticky  = |norm_lo[MAN_W-1:0];

`ifdef FPMUL_RNE_EN
  assign round_up = guard & (sticky | norm_lo[MAN_W+1]);
`else
  assign round_up = 1'b0;
`endif

  assign frac_sum  = {1'b0, norm_lo[PW-2 -: MAN_W]} + {{MAN_W{1'b0}}, round_up};
  assign rnd_carry = frac_sum[MAN_W];
  assign exp3      = exp2_q + $signed({{(EW-1){1'b0}}, msb})
                            + $signed({{(EW-1){1'b0}}, rnd_carry});

  always_comb begin
    res_d = '0;
    flg_d = '0;
    case (cls2_q)
      FP_NAN: begin
        res_d               = QNAN;
        flg_d[FLAG_INVALID] = inv2_q;
      end
      FP_INF:  res_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: res_d = {sign2_q, {(W-1){1'b0}}};
      default: begin
        if (exp3 >= EXP_MAX) begin
          res_d                 = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_d[FLAG_OVERFLOW]  = 1'b1;
          flg_d[FLAG_INEXACT]   = 1'b1;
        end else if (exp3 <= EXP_ZERO) begin
          res_d                 = {sign2_q, {(W-1){1'b0}}};
          flg_d[FLAG_UNDERFLOW] = 1'b1;
          flg_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          // On rounding carry the fraction wraps to zero, exponent already bumped.
          res_d               = {sign2_q, exp3[EXP_W-1:0], frac_sum[MAN_W-1:0]};
          flg_d[FLAG_INEXACT] = guard | sticky;
        end
      end
    endcase
  end

  logic              out_valid_q;
  logic [W-1:0]      result_q;
  logic [FLAG_W-1:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        result_q <= res_d;
        flags_q  <= flg_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32): directed vectors, stall stream,
// and reset with items in flight.
module tb_fp_mul_pipe;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned W     = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          issue;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] cur_res;
  logic [3:0]  cur_flg;
  bit          cur_lat;

`ifdef FPMUL_RNE_EN
  localparam logic [31:0] RND_RES = 32'h3FC00002;
`else
  localparam logic [31:0] RND_RES = 32'h3FC00001;
`endif

  // a, b, expected result, expected flags {invalid, overflow, underflow, inexact}
  logic [31:0] va[12] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h7F000000,
                          32'h00800000, 32'h7F800000, 32'hFFC00000, 32'h80000000,
                          32'h00400000, 32'h7F800000, 32'hC0400000, 32'h3F800001};
  logic [31:0] vb[12] = '{32'h40000000, 32'h3FC00000, 32'h3FC00000, 32'h40000000,
                          32'h3F000000, 32'h00000000, 32'h3F800000, 32'h40000000,
                          32'h3F800000, 32'hC0000000, 32'h40400000, 32'h3F800001};
  logic [31:0] vr[12] = '{32'h40C00000, 32'h40100000, RND_RES,      32'h7F800000,
                          32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                          32'h00000000, 32'hFF800000, 32'hC1100000, 32'h3F800002};
  logic [3:0]  vf[12] = '{4'h0, 4'h0, 4'h1, 4'h5, 4'h3, 4'h8, 4'h0, 4'h0,
                          4'h0, 4'h0, 4'h0, 4'h1};

  // 1.0 .. 8.0 times 2.0
  logic [31:0] sa_v[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] sr_v[8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                           32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Input side: record each accepted pair's expected response.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{cur_res, cur_flg, cyc, cur_lat});
  end

  // Output side: compare whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", result);
      end else begin
        e = sb[0];
        check("result", result, e.res);
        check("flags", {28'b0, flags}, {28'b0, e.flg});
        if (!out_ready) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        else begin
          if (e.chk_lat) check("latency", cyc - e.issue, 32'd3);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] r, input logic [3:0] f, input bit lat);
    bit acc;
    int n;
    a = ia; b = ib; cur_res = r; cur_flg = f; cur_lat = lat;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck low, expected 1");
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    cur_res = '0; cur_flg = '0; cur_lat = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_result", result, 32'd0);
    check("reset_flags", {28'b0, flags}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) issue(va[i], vb[i], vr[i], vf[i], 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++) issue(sa_v[i], 32'h40000000, sr_v[i], 4'h0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    issue(32'h40400000, 32'h40000000, 32'h40C00000, 4'h0, 1'b0);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_flush_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(32'hC0400000, 32'h40400000, 32'hC1100000, 4'h0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
